// File: rtl/adder_pkg.sv
// Shared types and elaboration helpers for the multi-cycle adder.
package adder_pkg;

    // Control states of the slice sequencer.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    // True when WIDTH splits into a whole number of non-empty slices.
    function automatic bit widths_ok(input int width, input int slice);
        return (slice > 0) && (width > 0) && ((width % slice) == 0);
    endfunction

    // Width of the slice index: $clog2(n), but never less than one bit.
    function automatic int count_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rca_slice.sv
// SLICE-bit combinational ripple-carry adder. It also exposes the carry
// into its top bit, so the caller can derive signed overflow.
module rca_slice #(
    parameter int SLICE = 4
) (
    input  logic [SLICE-1:0] a,
    input  logic [SLICE-1:0] b,
    input  logic             ci,
    output logic [SLICE-1:0] sum,
    output logic             co,
    output logic             c_msb
);

    logic rc;

    // Ripple the carry from the LSB to the MSB of the slice.
    always_comb begin
        // NOTE: give every combinational output a default first; a path that leaves one unassigned would infer a latch.
        sum   = '0;
        c_msb = 1'b0;
        // NOTE: blocking assignments here, because each bit reads the carry produced by the bit before it in the same pass.
        rc    = ci;
        for (int i = 0; i < SLICE; i++) begin
            if (i == SLICE - 1) begin
                c_msb = rc;
            end
            sum[i] = a[i] ^ b[i] ^ rc;
            rc     = (a[i] & b[i]) | (rc & (a[i] ^ b[i]));
        end
        co = rc;
    end

endmodule

// File: rtl/multicycle_adder.sv
// Multi-cycle add/subtract unit. Operands are accepted in IDLE. One
// SLICE-bit slice is added per clock from LSB to MSB through a single
// rca_slice, and the result is held in DONE until downstream takes it.
module multicycle_adder
    import adder_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int SLICE = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             c_in,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             c_out,
    output logic             ovf
);

    localparam int            NSLICE = WIDTH / SLICE;
    localparam int            KW     = count_width(NSLICE);
    localparam logic [KW-1:0] K_LAST = KW'(NSLICE - 1);

    // Stop elaboration when WIDTH is not a whole number of slices.
    if (!widths_ok(WIDTH, SLICE)) begin : g_bad_width
        $error("multicycle_adder: WIDTH must be a positive multiple of SLICE");
    end

    state_e           state_q, state_d;
    logic [KW-1:0]    k_q, k_d;
    logic [WIDTH-1:0] x_q, y_q;
    logic [WIDTH-1:0] s_q, s_d;
    logic             carry_q, carry_d;
    logic             c_out_q, c_out_d;
    logic             ovf_q, ovf_d;
    logic             accept;

    int               base;
    logic [SLICE-1:0] a_sl, b_sl, sum_sl;
    logic             co_sl, cmsb_sl;

    // The slice currently being added is selected by the slice index.
    assign base = int'(k_q) * SLICE;
    assign a_sl = x_q[base +: SLICE];
    assign b_sl = y_q[base +: SLICE];

    rca_slice #(
        .SLICE (SLICE)
    ) u_rca_slice (
        .a     (a_sl),
        .b     (b_sl),
        .ci    (carry_q),
        .sum   (sum_sl),
        .co    (co_sl),
        .c_msb (cmsb_sl)
    );

    assign accept = (state_q == IDLE) && in_valid;

    // Control state, slice index, carry chain and result registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            k_q     <= '0;
            carry_q <= 1'b0;
            s_q     <= '0;
            c_out_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments for registers, so every flop samples values from before this edge.
            state_q <= state_d;
            k_q     <= k_d;
            carry_q <= carry_d;
            s_q     <= s_d;
            c_out_q <= c_out_d;
            ovf_q   <= ovf_d;
        end
    end

    // Operand capture. Subtraction is folded in here by storing ~y.
    always_ff @(posedge clk) begin
        // NOTE: the operand registers have no reset; they are only read in BUSY, after an accept has loaded them.
        if (accept) begin
            x_q <= x;
            y_q <= sub ? ~y : y;
        end
    end

    // Next-state logic: accept, add one slice per cycle, hold the result.
    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        carry_d = carry_q;
        s_d     = s_q;
        c_out_d = c_out_q;
        ovf_d   = ovf_q;

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    carry_d = c_in ^ sub;
                    k_d     = '0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                s_d[base +: SLICE] = sum_sl;
                carry_d            = co_sl;
                if (k_q == K_LAST) begin
                    c_out_d = co_sl;
                    ovf_d   = cmsb_sl ^ co_sl;
                    state_d = DONE;
                end else begin
                    k_d = k_q + 1'b1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign s         = s_q;
    assign c_out     = c_out_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_multicycle_adder.sv
// Self-checking bench for multicycle_adder. Four instances cover the
// configurations 16/4, 4/4, 32/8 and 8/1. Directed cases and random
// operations are compared against an integer-arithmetic reference model.
module tb_multicycle_adder;

    logic        clk;
    logic        rst;
    logic [31:0] x_b, y_b;
    logic        c_in_b, sub_b;
    logic [3:0]  in_valid, out_ready;
    logic [3:0]  in_ready, out_valid, c_out, ovf;
    logic [31:0] s_w [4];

    logic [15:0] s16;
    logic [3:0]  s4;
    logic [31:0] s32;
    logic [7:0]  s8;

    int n_checks = 0;
    int n_errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    multicycle_adder #(.WIDTH(16), .SLICE(4)) u_dut16 (
        .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .x(x_b[15:0]), .y(y_b[15:0]), .c_in(c_in_b), .sub(sub_b),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]),
        .s(s16), .c_out(c_out[0]), .ovf(ovf[0]));

    multicycle_adder #(.WIDTH(4), .SLICE(4)) u_dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .x(x_b[3:0]), .y(y_b[3:0]), .c_in(c_in_b), .sub(sub_b),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]),
        .s(s4), .c_out(c_out[1]), .ovf(ovf[1]));

    multicycle_adder #(.WIDTH(32), .SLICE(8)) u_dut32 (
        .clk(clk), .rst(rst), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
        .x(x_b), .y(y_b), .c_in(c_in_b), .sub(sub_b),
        .out_valid(out_valid[2]), .out_ready(out_ready[2]),
        .s(s32), .c_out(c_out[2]), .ovf(ovf[2]));

    multicycle_adder #(.WIDTH(8), .SLICE(1)) u_dut8 (
        .clk(clk), .rst(rst), .in_valid(in_valid[3]), .in_ready(in_ready[3]),
        .x(x_b[7:0]), .y(y_b[7:0]), .c_in(c_in_b), .sub(sub_b),
        .out_valid(out_valid[3]), .out_ready(out_ready[3]),
        .s(s8), .c_out(c_out[3]), .ovf(ovf[3]));

    assign s_w[0] = {16'd0, s16};
    assign s_w[1] = {28'd0, s4};
    assign s_w[2] = s32;
    assign s_w[3] = {24'd0, s8};

    function automatic int wid(input int d);
        case (d)
            0:       return 16;
            1:       return 4;
            2:       return 32;
            default: return 8;
        endcase
    endfunction

    function automatic int nsl(input int d);
        case (d)
            0:       return 4;
            1:       return 1;
            2:       return 4;
            default: return 8;
        endcase
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: exact integer sum/difference, then wrap to w bits. The
    // carry flag means "result >= 2^w" for add and "no borrow" for subtract.
    // Overflow means the signed result does not fit in w bits.
    function automatic void model(input int w, input logic [31:0] xa, input logic [31:0] ya,
                                  input bit ci, input bit sb,
                                  output logic [31:0] es, output bit ec, output bit ev);
        longint m, half, ux, uy, sx, sy, c, r, rs;
        m    = (longint'(1) << w) - 1;
        half = longint'(1) << (w - 1);
        ux   = longint'(xa) & m;
        uy   = longint'(ya) & m;
        sx   = (ux >= half) ? ux - (m + 1) : ux;
        sy   = (uy >= half) ? uy - (m + 1) : uy;
        c    = ci ? 1 : 0;
        if (sb) begin
            r  = ux - uy - c;
            rs = sx - sy - c;
            ec = (r >= 0);
        end else begin
            r  = ux + uy + c;
            rs = sx + sy + c;
            ec = (r > m);
        end
        es = 32'(r & m);
        ev = (rs >= half) || (rs < -half);
    endfunction

    // Present operands to instance d and return right after the accept edge.
    task automatic issue(input int d, input logic [31:0] xa, input logic [31:0] ya,
                         input bit ci, input bit sb);
        int n = 0;
        while (!in_ready[d] && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check($sformatf("d%0d_ready_wait", d), 64'(in_ready[d]), 64'd1);
        x_b = xa; y_b = ya; c_in_b = ci; sub_b = sb;
        in_valid[d] = 1'b1;
        @(posedge clk); #1;
        in_valid[d] = 1'b0;
        // Scramble inputs: the unit must use the values captured at accept.
        x_b = $urandom; y_b = $urandom;
        c_in_b = 1'($urandom_range(0, 1)); sub_b = 1'($urandom_range(0, 1));
    endtask

    // From just after accept: check latency and result, hold while out_ready
    // toggles randomly, and check the handshake returns the unit to idle.
    task automatic drain(input int d, input logic [31:0] es, input bit ec, input bit ev);
        int lat = 0;
        bit seen = 1'b0;
        bit hs;
        out_ready[d] = 1'($urandom_range(0, 1));
        forever begin
            if (lat > 300) begin
                check($sformatf("d%0d_timeout", d), 64'(out_valid[d]), 64'd1);
                break;
            end
            if (out_valid[d]) begin
                if (!seen) begin
                    seen = 1'b1;
                    check($sformatf("d%0d_latency", d), 64'(lat), 64'(nsl(d)));
                    check($sformatf("d%0d_s", d), 64'(s_w[d]), 64'(es));
                    check($sformatf("d%0d_c_out", d), 64'(c_out[d]), 64'(ec));
                    check($sformatf("d%0d_ovf", d), 64'(ovf[d]), 64'(ev));
                end else begin
                    check($sformatf("d%0d_hold", d), {30'd0, c_out[d], ovf[d], s_w[d]},
                          {30'd0, ec, ev, es});
                end
            end
            check($sformatf("d%0d_in_ready_busy", d), 64'(in_ready[d]), 64'd0);
            hs = out_valid[d] && out_ready[d];
            @(posedge clk); #1;
            lat++;
            if (hs) begin
                check($sformatf("d%0d_valid_drop", d), 64'(out_valid[d]), 64'd0);
                check($sformatf("d%0d_ready_back", d), 64'(in_ready[d]), 64'd1);
                break;
            end
            out_ready[d] = 1'($urandom_range(0, 1));
        end
        out_ready[d] = 1'b0;
    endtask

    task automatic run_op(input int d, input logic [31:0] xa, input logic [31:0] ya,
                          input bit ci, input bit sb);
        logic [31:0] es;
        bit ec, ev;
        model(wid(d), xa, ya, ci, sb, es, ec, ev);
        issue(d, xa, ya, ci, sb);
        drain(d, es, ec, ev);
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 7))
            0:       return 32'hFFFF_FFFF;
            1:       return 32'h0000_0000;
            2:       return 32'h8000_8080;
            3:       return 32'h7FFF_7F7F;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] es_a, es_b;
        bit ec_a, ev_a, ec_b, ev_b;
        int n;

        rst = 1'b1;
        in_valid = '0; out_ready = '0;
        x_b = '0; y_b = '0; c_in_b = 1'b0; sub_b = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk); #1;
        for (int d = 0; d < 4; d++) begin
            check($sformatf("d%0d_rst_in_ready", d), 64'(in_ready[d]), 64'd1);
            check($sformatf("d%0d_rst_out_valid", d), 64'(out_valid[d]), 64'd0);
            check($sformatf("d%0d_rst_flags", d), {30'd0, c_out[d], ovf[d], s_w[d]}, 64'd0);
        end

        // NSLICE = 1: behaves as the plain 4-bit adder with 1-cycle latency.
        run_op(1, 32'hF, 32'hF, 1'b0, 1'b0);
        for (int i = 0; i < 16; i++) begin
            for (int j = 0; j < 16; j++) begin
                run_op(1, 32'(i), 32'(j), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            end
        end

        // 16/4 directed cases: full carry ripple, signed overflow, borrow.
        run_op(0, 32'h0FFF, 32'h0001, 1'b0, 1'b0);
        run_op(0, 32'h7FFF, 32'h0001, 1'b0, 1'b0);
        run_op(0, 32'h0003, 32'h0005, 1'b0, 1'b1);
        run_op(0, 32'h8000, 32'h0001, 1'b1, 1'b1);
        run_op(0, 32'hFFFF, 32'h0000, 1'b1, 1'b0);

        // Back-pressure: result held for 10 cycles while new operands wait.
        model(16, 32'h1357, 32'h2468, 1'b1, 1'b0, es_a, ec_a, ev_a);
        model(16, 32'h9ABC, 32'h1111, 1'b0, 1'b1, es_b, ec_b, ev_b);
        issue(0, 32'h1357, 32'h2468, 1'b1, 1'b0);
        n = 0;
        while (!out_valid[0] && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check("bp_valid", 64'(out_valid[0]), 64'd1);
        x_b = 32'h9ABC; y_b = 32'h1111; c_in_b = 1'b0; sub_b = 1'b1;
        in_valid[0] = 1'b1;
        repeat (10) begin
            @(posedge clk); #1;
            check("bp_in_ready", 64'(in_ready[0]), 64'd0);
            check("bp_out_valid", 64'(out_valid[0]), 64'd1);
            check("bp_hold", {30'd0, c_out[0], ovf[0], s_w[0]}, {30'd0, ec_a, ev_a, es_a});
        end
        out_ready[0] = 1'b1;
        @(posedge clk); #1;
        out_ready[0] = 1'b0;
        check("bp_release_ready", 64'(in_ready[0]), 64'd1);
        check("bp_release_valid", 64'(out_valid[0]), 64'd0);
        @(posedge clk); #1;
        in_valid[0] = 1'b0;
        check("bp_accept", 64'(in_ready[0]), 64'd0);
        drain(0, es_b, ec_b, ev_b);

        // Reset in the middle of an operation (while slice 2 is pending).
        issue(0, 32'hABCD, 32'h1111, 1'b0, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check("mid_rst_s", 64'(s_w[0]), 64'd0);
        check("mid_rst_valid", 64'(out_valid[0]), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            check("post_rst_valid", 64'(out_valid[0]), 64'd0);
            check("post_rst_ready", 64'(in_ready[0]), 64'd1);
            check("post_rst_state", {30'd0, c_out[0], ovf[0], s_w[0]}, 64'd0);
        end
        run_op(0, 32'h1234, 32'h4321, 1'b0, 1'b0);

        // Random regression on 16/4, 32/8 and 8/1.
        for (int k = 0; k < 3; k++) begin
            int d;
            d = (k == 0) ? 0 : ((k == 1) ? 2 : 3);
            for (int i = 0; i < 1000; i++) begin
                run_op(d, pick_operand(), pick_operand(),
                       1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/multicycle_adder.md
# multicycle_adder

Parametrised multi-cycle add/subtract unit that sums two WIDTH-bit operands through a single SLICE-bit ripple-carry slice, processing one slice per clock from LSB to MSB. It replaces the fixed 4-bit combinational ripple-carry adder wherever wide operands must be added without a long carry chain. Operands enter and results leave over valid/ready handshakes.

## Interface

- WIDTH, 16, operand and result width; must be a positive multiple of SLICE
- SLICE, 4, bits added per cycle; NSLICE = WIDTH/SLICE cycles per operation
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  operand set presented
- in_ready  output  1  unit can accept operands (high only in IDLE)
- x  input  WIDTH  operand A
- y  input  WIDTH  operand B
- c_in  input  1  carry-in for add; borrow-in for subtract
- sub  input  1  0: s = x + y + c_in; 1: s = x - y - c_in
- out_valid  output  1  result held and valid
- out_ready  input  1  downstream accepts result
- s  output  WIDTH  sum/difference
- c_out  output  1  raw carry out of MSB; in subtract, 1 = no borrow
- ovf  output  1  two's-complement overflow

## Operation

- States: IDLE, BUSY, DONE.
- IDLE: in_ready = 1. On in_valid && in_ready, latch x, y_eff = sub ? ~y : y, carry = c_in ^ sub, clear slice index k, go to BUSY. Inputs are ignored after the accept edge.
- BUSY: each cycle, add slice k of x and y_eff plus carry, and write the result into s[k*SLICE +: SLICE]. Carry is registered into the next slice. When k = NSLICE-1, latch c_out = final carry and ovf = carry into MSB XOR carry out of MSB, then go to DONE. Otherwise k increments.
- DONE: out_valid = 1. s, c_out and ovf are held stable. On out_ready, go to IDLE.
- No operand accept in BUSY or DONE. in_ready is derived combinationally from state only and never depends on in_valid.
- Arithmetic is modulo 2^WIDTH. Carries are never lost or double-counted across slice boundaries.
- Reset, including mid-operation: state IDLE, k = 0, s = 0, c_out = 0, ovf = 0, out_valid = 0, and in_ready = 1 after reset release. An aborted operation produces no output.
- s holds the previous result while idle. Partial bits of the new result are visible during BUSY, but s is only meaningful while out_valid = 1.

## Timing

- Accept at edge E0. Slices are computed at edges E1..ENSLICE. out_valid rises after edge ENSLICE, giving a latency of NSLICE cycles from accept to out_valid.
- Result handshake at edge Ed. in_ready is high the cycle after Ed, so the earliest next accept is edge Ed+1.
- Minimum throughput is one operation per NSLICE+2 cycles with out_ready tied high.
- When NSLICE = 1 the unit behaves as the 4-bit adder with a 1-cycle latency.
- out_ready held low stalls the unit indefinitely in DONE with outputs stable. in_valid during this time is not accepted.

## Structure

- Shared package adder_pkg holds:
  - the state enum typedef (IDLE, BUSY, DONE);
  - a width-check helper/localparam used to assert WIDTH % SLICE == 0 at elaboration.
- One sub-module, rca_slice (combinational, parameter SLICE), provides the SLICE-bit ripple-carry adder. It has ports a, b, ci, sum, co, and c_msb (the carry into its top bit, used for ovf). It is instantiated once.
- Slice counter width is $clog2(NSLICE) with a minimum of 1.

## Test plan

- WIDTH=4, SLICE=4, add: x=1111, y=1111, c_in=0 -> s=1110, c_out=1, ovf=0, out_valid one cycle after accept. The vector set 0000+0000 through 1110+1101 also matches combinational sums.
- WIDTH=16, SLICE=4, add: x=0x0FFF, y=0x0001 -> s=0x1000, c_out=0, ovf=0, out_valid 4 cycles after accept (carry ripples across all slices).
- WIDTH=16, SLICE=4, add: x=0x7FFF, y=0x0001 -> s=0x8000, ovf=1, c_out=0. Subtract: x=0x0003, y=0x0005, c_in=0 -> s=0xFFFE, c_out=0 (borrow), ovf=0.
- Back-pressure: hold out_ready=0 for 10 cycles while in_valid=1 with new operands -> result stable, in_ready=0, no second accept; release out_ready -> next operation accepted one cycle later.
- Assert rst during BUSY at slice 2 -> out_valid stays 0, s=0, in_ready=1 after release, and the following operation 0x1234+0x4321 gives 0x5555.
- Random regression of 1000 operations with out_ready toggled randomly, for WIDTH/SLICE pairs 16/4, 32/8 and 8/1 -> every result matches the reference model for s, c_out and ovf.
